// File: rtl/imem_loader_pkg.sv
// Shared instruction-memory loader constants.
//   IMEM_ADDR_W   : default byte-address width of the instruction memory
//   FRAME_HDR_LEN : number of little-endian length bytes that open a frame
package imem_loader_pkg;

    localparam int unsigned IMEM_ADDR_W   = 10;
    localparam int unsigned FRAME_HDR_LEN = 4;

    // Memory capacity in bytes. It is returned as 32 bits so that it can be
    // compared directly against the 32-bit frame length.
    function automatic logic [31:0] imem_capacity(input int unsigned aw);
        return 32'(1) << aw;
    endfunction

endpackage

// File: rtl/imem_loader_stream_byte_sink.sv
// Stream byte sink: valid/ready acceptance plus a one-cycle registered
// instruction-memory write stage.
//   clk, rst            : clock, asynchronous active-low reset
//   ready               : loader is able to take a byte (state-derived)
//   in_valid, in_data   : incoming stream byte
//   wr_sel              : an accepted byte is payload and must be written
//   wr_addr             : target address for an accepted payload byte
//   accept              : byte transfers on this edge
//   mem_we/addr/wdata   : registered byte write, one cycle after acceptance
module stream_byte_sink
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ready,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              accept,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata
);

    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    always_comb begin
        accept      = in_valid & ready;
        mem_we_d    = accept & wr_sel;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        // Address/data hold their last value outside a write.
        if (mem_we_d) begin
            mem_addr_d  = wr_addr;
            mem_wdata_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory program loader. It takes a framed byte stream
// (4-byte LE length N, N payload bytes, XOR checksum byte), writes the
// payload to byte addresses 0..N-1 and holds the CPU in reset until the
// checksum of a complete image matches.
//   clk, rst            : clock, asynchronous active-low reset
//   start               : arms a new load from IDLE, DONE or ERR
//   in_valid/in_ready   : stream handshake, in_data is the byte
//   mem_we/addr/wdata   : instruction-memory byte write port
//   cpu_rst             : active-high CPU reset hold
//   done / err          : level status of the last load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [31:0] CAP   = imem_capacity(ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       csum_q, csum_d;

    logic             ready, wr_sel, accept;
    logic [31:0]      len_next;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        ready    = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
        wr_sel   = (state_q == S_DATA);
        len_next = {in_data, len_q[31:8]};
        cnt_inc  = cnt_q + 1'b1;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    len_d   = '0;
                    cnt_d   = '0;
                    csum_d  = '0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    len_d = len_next;
                    cnt_d = cnt_inc;
                    // The counter is reused as the payload index, so it
                    // restarts from zero once the header is complete.
                    if (cnt_q == CNT_W'(FRAME_HDR_LEN - 1)) begin
                        cnt_d = '0;
                        if (len_next > CAP)
                            state_d = S_ERR;
                        else if (len_next == '0)
                            state_d = S_CSUM;
                        else
                            state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    cnt_d  = cnt_inc;
                    if (32'(cnt_inc) == len_q)
                        state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept)
                    state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
        end
    end

    stream_byte_sink #(
        .ADDR_W (ADDR_W)
    ) u_sink (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .wr_sel    (wr_sel),
        .wr_addr   (cnt_q[ADDR_W-1:0]),
        .accept    (accept),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    assign in_ready = ready;
    assign done     = (state_q == S_DONE);
    assign err      = (state_q == S_ERR);
    assign cpu_rst  = (state_q != S_DONE);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader: the writer side of the instruction memory the single-cycle and pipelined CPUs fetch from.
- Accepts a framed byte stream over a valid/ready handshake.
- Writes the payload bytes, little-endian, into byte-addressed instruction memory starting at address 0.
- Holds the CPU in reset until the image is loaded and its checksum verifies, replacing $readmemh preloading for hardware bring-up.

Parameters:
- ADDR_W, 10, instruction-memory byte-address width; capacity 2^ADDR_W bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; arms a new load from IDLE, DONE or ERR.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte.
- mem_we  out  1  instruction-memory byte write enable.
- mem_addr  out  ADDR_W  byte write address.
- mem_wdata  out  8  byte write data.
- cpu_rst  out  1  active-high CPU reset hold.
- done  out  1  load complete and checksum matched; level.
- err  out  1  load failed; level.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0.
  - cpu_rst=1.
  - Byte counter, length register and checksum accumulator cleared.
- Handshake:
  - A byte transfers on a rising edge with in_valid=1 and in_ready=1.
  - in_ready is 1 only in LEN, DATA and CSUM, and depends on state only, never on in_valid.
  - Throughput is one byte per cycle.
- Frame format: 4 length bytes (N, little-endian, LSB first), then N payload bytes, then 1 checksum byte equal to the XOR of all payload bytes.
- States:
  - IDLE: cpu_rst=1. On start -> LEN, clearing the length, counter and checksum.
  - LEN: accept 4 bytes into length[31:0]. After the 4th byte:
    - N > 2^ADDR_W -> ERR.
    - N = 0 -> CSUM.
    - otherwise -> DATA.
  - DATA: each accepted byte is written to memory and XORed into the checksum. After byte N -> CSUM.
  - CSUM: accept 1 byte. Equal to the accumulator -> DONE, otherwise -> ERR.
  - DONE: done=1, cpu_rst=0. On start -> LEN with done=0, cpu_rst=1, memory contents retained.
  - ERR: err=1, cpu_rst=1. On start -> LEN with err=0.
- Write timing:
  - The byte accepted at edge k appears as mem_we=1, mem_addr=index, mem_wdata=byte in the cycle after edge k, registered.
  - mem_we is 0 in every other cycle.
  - Payload byte i goes to address i, so byte 0 is the LSB of the word at address 0.
- Boundaries:
  - N = 2^ADDR_W is legal. The last address is 2^ADDR_W-1; the address counter never wraps into a write.
  - in_valid=0 mid-frame stalls without timeout; state and counters hold.
  - start in LEN, DATA or CSUM is ignored.
  - done/err change and cpu_rst deasserts on the edge that accepts the checksum byte. mem_we for the last payload byte has already completed by then.
  - Asynchronous reset mid-load aborts immediately; memory contents already written are left as is.
- Width rules: length is compared as 32-bit unsigned; the byte counter is ADDR_W+1 bits.

Decomposition:
- Shared package for instruction-memory interface constants: IMEM_ADDR_W default and the frame header length (4).
- State encoding localparams live in the module.
- One natural sub-module: stream_byte_sink, the handshake acceptance plus one-cycle registered write stage.
- The loader FSM instantiates it.

Test Plan:
- Load N=8 bytes 0x20,0x08,0x00,0x01,0x00,0x00,0x00,0x00 with checksum 0x29 -> 8 writes to addresses 0..7 with matching data, then done=1, cpu_rst=0, err=0.
- Same frame with checksum 0x28 -> all 8 writes occur, then err=1, done=0, cpu_rst=1.
- Length bytes 0x01,0x04,0x00,0x00 (N=1025) with ADDR_W=10 -> ERR after the 4th byte, no mem_we ever asserted.
- N=0 followed by checksum 0x00 -> done=1 with zero writes. N=1024 at full rate -> last write at address 1023 with no wrap.
- Toggle in_valid pseudo-randomly during DATA -> write count and order unchanged, in_ready stays high throughout DATA.
- Drive rst=0 after 3 of 8 payload bytes -> asynchronous return to IDLE with outputs at reset values. Then start plus a fresh valid frame -> done=1.
